// File: rtl/mux_nx1_seq_if.sv
// mux_nx1_seq_if: bus bundle for the registered N:1 channel multiplexer.
//
// Signals
//   en     advance/update enable (0 freezes the mux state)
//   mode   0 = manual select, 1 = auto-scan
//   s      manual channel select
//   I      packed channels, channel k = I[k*WIDTH +: WIDTH]
//   y      registered data of the selected channel
//   sel_q  channel currently presented on y
//   valid  y holds data from a legal channel
//   wrap   one-cycle pulse when the scan wraps N-1 -> 0
//
// Modports
//   master  drives en/mode/s/I, observes the registered outputs
//   slave   the multiplexer itself
interface mux_nx1_seq_if #(
    parameter int N     = 8,
    parameter int WIDTH = 1
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic                 en;
    logic                 mode;
    logic [SELW-1:0]      s;
    logic [N*WIDTH-1:0]   I;
    logic [WIDTH-1:0]     y;
    logic [SELW-1:0]      sel_q;
    logic                 valid;
    logic                 wrap;

    modport master (
        output en, mode, s, I,
        input  y, sel_q, valid, wrap
    );

    modport slave (
        input  en, mode, s, I,
        output y, sel_q, valid, wrap
    );
endinterface

// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: registered N-channel, WIDTH-bit multiplexer with a manual
// mode (channel chosen by s) and an auto-scan mode (internal counter steps
// through the channels, holding each one for DWELL enabled cycles).
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (overrides en and mode)
//   bus   mux_nx1_seq_if.slave: en, mode, s, I in; y, sel_q, valid, wrap out
//
// y and sel_q are loaded on the same edge from the same next-select value,
// so the data on y always belongs to the channel reported on sel_q.
module mux_nx1_seq #(
    parameter int N     = 8,
    parameter int WIDTH = 1,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_nx1_seq_if.slave  bus
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    logic [WIDTH-1:0] y_q,     y_d;
    logic [SELW-1:0]  sel_q,   sel_d;
    logic             valid_q, valid_d;
    logic             wrap_q,  wrap_d;
    logic [CNTW-1:0]  cnt_q,   cnt_d;

    // Loop-compare selection keeps every part-select in range even when
    // the select code space is larger than N (non-power-of-2 N).
    function automatic logic [WIDTH-1:0] pick(
        input logic [N*WIDTH-1:0] data,
        input logic [SELW-1:0]    sel
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                r = data[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    function automatic logic is_legal(input logic [SELW-1:0] sel);
        return ({1'b0, sel} < (SELW + 1)'(N));
    endfunction

    always_comb begin
        sel_d   = sel_q;
        y_d     = y_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (bus.en) begin
            if (!bus.mode) begin
                // Manual: the dwell counter is kept at zero so that a later
                // switch to scan holds the current channel for a full dwell.
                cnt_d = '0;
                if (is_legal(bus.s)) begin
                    sel_d   = bus.s;
                    y_d     = pick(bus.I, bus.s);
                    valid_d = 1'b1;
                end else begin
                    y_d     = '0;
                    valid_d = 1'b0;
                end
            end else begin
                valid_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sel_q == SEL_LAST) begin
                        sel_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        sel_d = sel_q + SELW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                // Live data: re-sample the (possibly new) channel every cycle.
                y_d = pick(bus.I, sel_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.sel_q = sel_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_mux_nx1_seq.sv
// Directed testbench for mux_nx1_seq: three instances cover N=8/DWELL=4,
// N=6/DWELL=1 and N=6/DWELL=3.
module tb_mux_nx1_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [2:0] s;
        logic [3:0] y;
        logic [2:0] sel;
        logic       valid;
    } mvec_t;

    mvec_t v8[8];
    mvec_t v6[5];

    logic [7:0]  i8_pat;
    logic [23:0] i6_pat;
    logic [23:0] i6_new;

    mux_nx1_seq_if #(.N(8), .WIDTH(1)) b8();
    mux_nx1_seq_if #(.N(6), .WIDTH(4)) b6a();
    mux_nx1_seq_if #(.N(6), .WIDTH(4)) b6b();

    mux_nx1_seq #(.N(8), .WIDTH(1), .DWELL(4)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));
    mux_nx1_seq #(.N(6), .WIDTH(4), .DWELL(1)) u6a (.clk(clk), .rst(rst), .bus(b6a.slave));
    mux_nx1_seq #(.N(6), .WIDTH(4), .DWELL(3)) u6b (.clk(clk), .rst(rst), .bus(b6b.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic y, input logic [2:0] sel,
                        input logic valid, input logic wrap);
        chk({tag, ".y"},     32'(b8.y),     32'(y));
        chk({tag, ".sel"},   32'(b8.sel_q), 32'(sel));
        chk({tag, ".valid"}, 32'(b8.valid), 32'(valid));
        chk({tag, ".wrap"},  32'(b8.wrap),  32'(wrap));
    endtask

    task automatic chk6a(input string tag, input logic [3:0] y, input logic [2:0] sel,
                         input logic valid, input logic wrap);
        chk({tag, ".y"},     32'(b6a.y),     32'(y));
        chk({tag, ".sel"},   32'(b6a.sel_q), 32'(sel));
        chk({tag, ".valid"}, 32'(b6a.valid), 32'(valid));
        chk({tag, ".wrap"},  32'(b6a.wrap),  32'(wrap));
    endtask

    initial begin
        // I8 = 8'b11001100 -> channels 0..7 = 0,0,1,1,0,0,1,1
        i8_pat = 8'b11001100;
        // N=6 channels 0..5 = 3,5,9,A,C,E
        i6_pat = {4'hE, 4'hC, 4'hA, 4'h9, 4'h5, 4'h3};

        v8[0] = '{3'd0, 4'd0, 3'd0, 1'b1};
        v8[1] = '{3'd1, 4'd0, 3'd1, 1'b1};
        v8[2] = '{3'd2, 4'd1, 3'd2, 1'b1};
        v8[3] = '{3'd3, 4'd1, 3'd3, 1'b1};
        v8[4] = '{3'd4, 4'd0, 3'd4, 1'b1};
        v8[5] = '{3'd5, 4'd0, 3'd5, 1'b1};
        v8[6] = '{3'd6, 4'd1, 3'd6, 1'b1};
        v8[7] = '{3'd7, 4'd1, 3'd7, 1'b1};

        v6[0] = '{3'd2, 4'h9, 3'd2, 1'b1};
        v6[1] = '{3'd6, 4'h0, 3'd2, 1'b0};
        v6[2] = '{3'd7, 4'h0, 3'd2, 1'b0};
        v6[3] = '{3'd5, 4'hE, 3'd5, 1'b1};
        v6[4] = '{3'd6, 4'h0, 3'd5, 1'b0};

        rst = 1'b1;
        b8.en  = 1'b0; b8.mode  = 1'b0; b8.s  = '0; b8.I  = i8_pat;
        b6a.en = 1'b0; b6a.mode = 1'b0; b6a.s = '0; b6a.I = i6_pat;
        b6b.en = 1'b0; b6b.mode = 1'b0; b6b.s = '0; b6b.I = i6_pat;
        step();
        chk8("reset8", 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // N=8 manual sweep
        b8.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b8.s = v8[i].s;
            step();
            chk8($sformatf("man8[%0d]", i), v8[i].y[0], v8[i].sel, v8[i].valid, 1'b0);
        end

        // Manual -> scan from channel 7: held for the full dwell, then wraps
        b8.mode = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk8($sformatf("m2s[%0d]", c), 1'b1, 3'd7, 1'b1, 1'b0);
        end
        step();
        chk8("m2s_wrap", 1'b0, 3'd0, 1'b1, 1'b1);

        // Scan -> manual takes s on the next enabled cycle
        b8.mode = 1'b0;
        b8.s    = 3'd3;
        step();
        chk8("s2m", 1'b1, 3'd3, 1'b1, 1'b0);
        b8.en = 1'b0;

        // N=6 manual with illegal selects, then scan entry with valid=0
        b6a.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b6a.s = v6[i].s;
            step();
            chk6a($sformatf("man6[%0d]", i), v6[i].y, v6[i].sel, v6[i].valid, 1'b0);
        end
        b6a.mode = 1'b1;
        step();
        chk6a("ill2scan0", 4'h3, 3'd0, 1'b1, 1'b1);
        step();
        chk6a("ill2scan1", 4'h5, 3'd1, 1'b1, 1'b0);
        b6a.en = 1'b0;

        // N=6 DWELL=1 scan from reset: 1,2,3,4,5,0,1
        rst = 1'b1;
        step();
        chk6a("reset6a", 4'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        b6a.en = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            logic [2:0] es;
            es = 3'(c % 6);
            step();
            chk6a($sformatf("scan6[%0d]", c), i6_pat[es*4 +: 4], es, 1'b1, (c == 6));
        end
        b6a.en = 1'b0;

        // N=8 DWELL=4 scan, 40 cycles after reset
        rst = 1'b1;
        step();
        chk8("reset8b", 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        b8.mode = 1'b1;
        b8.en   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            logic [2:0] es;
            es = 3'((c / 4) % 8);
            step();
            chk8($sformatf("scan8[%0d]", c), i8_pat[es], es, 1'b1, (c == 32));
        end
        step();
        chk8("pre_freeze", 1'b1, 3'd2, 1'b1, 1'b0);

        // Freeze mid-dwell on channel 2 with changed inputs
        b8.en = 1'b0;
        b8.I  = ~i8_pat;
        for (int c = 0; c < 3; c++) begin
            step();
            chk8($sformatf("freeze[%0d]", c), 1'b1, 3'd2, 1'b1, 1'b0);
        end
        b8.I  = i8_pat;
        b8.en = 1'b1;
        step();
        chk8("resume0", 1'b1, 3'd2, 1'b1, 1'b0);
        step();
        chk8("resume1", 1'b1, 3'd2, 1'b1, 1'b0);
        step();
        chk8("resume2", 1'b1, 3'd3, 1'b1, 1'b0);

        // Run to sel_q=5 with cnt=2, then reset for one cycle
        repeat (10) step();
        chk8("pre_rst", 1'b0, 3'd5, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk8("mid_rst", 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk8($sformatf("post_rst[%0d]", c), 1'b0, 3'd0, 1'b1, 1'b0);
        end
        step();
        chk8("post_rst_adv", 1'b0, 3'd1, 1'b1, 1'b0);
        b8.en = 1'b0;

        // N=6 DWELL=3: live data change on channel 3
        rst = 1'b1;
        step();
        rst = 1'b0;
        b6b.mode = 1'b1;
        b6b.en   = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("scan6b[%0d].sel", c), 32'(b6b.sel_q), 32'(c / 3));
        end
        i6_new = i6_pat;
        i6_new[15:12] = 4'h7;
        b6b.I = i6_new;
        step();
        chk("live.y",   32'(b6b.y),     32'h7);
        chk("live.sel", 32'(b6b.sel_q), 32'd3);
        b6b.en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_nx1_seq.md
Name: mux_nx1_seq

Overview:
Parametrised, registered N-channel, WIDTH-bit multiplexer; next generation of the team's combinational 8:1 mux. Two modes: manual (select driven by s) and auto-scan (internal counter steps through channels with a programmable dwell time). Output, current select and status are registered. Used as a channel sequencer ahead of sampling/monitor logic.

Parameters:
N, 8, number of input channels (>=2, need not be a power of 2)
WIDTH, 1, bits per channel
SELW, $clog2(N), select width (derived, not overridden)
DWELL, 4, cycles each channel is held in scan mode (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  advance/update enable; 0 freezes all state
mode  input  1  0 = manual, 1 = auto-scan
s  input  SELW  manual channel select
I  input  N*WIDTH  packed channels; channel k = I[k*WIDTH +: WIDTH]
y  output  WIDTH  registered selected channel data
sel_q  output  SELW  channel currently presented on y
valid  output  1  y holds data from a legal channel
wrap  output  1  one-cycle pulse when scan wraps N-1 -> 0

Behaviour:
- One clock; rst synchronous, active-high, overrides en and mode.
- Reset values: y=0, sel_q=0, valid=0, wrap=0, dwell counter cnt=0.
- sel_nxt = value sel_q takes at the edge; y <= I[sel_nxt] at the same edge, so y and sel_q are always aligned. Latency: 1 cycle input-to-y.
- en=0: y, sel_q, valid, cnt hold; wrap=0. Input changes ignored.
- Manual (mode=0, en=1):
  - s<N: sel_q<=s, y<=I[s], valid<=1; cnt<=0.
  - s>=N (only possible for non-power-of-2 N): sel_q holds, y<=0, valid<=0.
  - wrap always 0.
- Scan (mode=1, en=1):
  - cnt increments each cycle; at cnt==DWELL-1: cnt<=0, sel_q<=(sel_q==N-1)?0:sel_q+1.
  - Otherwise sel_q holds; y still re-samples I[sel_q] every enabled cycle (live data).
  - valid<=1 on every enabled scan cycle.
  - wrap<=1 exactly on the edge where sel_q goes N-1 -> 0, else 0.
  - DWELL=1: channel advances every enabled cycle.
- Mode switch manual->scan: cnt<=0, scan starts from current sel_q (held DWELL cycles). Scan->manual: next enabled cycle takes s; cnt cleared.
- Entering scan with valid=0 (after illegal s): scan starts from held sel_q, valid<=1 on first scan cycle.
- Reset mid-scan: next cycle all outputs at reset values; if mode=1, en=1 after release, scan restarts at channel 0 with full dwell.
- Non-power-of-2 N: counter wraps at N-1, never emits sel_q>=N.

Test Plan:
- N=8, WIDTH=1, I=8'b11001100, mode=0, en=1, s=0..7 one per cycle -> y one cycle later = 0,0,1,1,0,0,1,1; sel_q tracks s; valid=1, wrap=0.
- Same I, mode=1, DWELL=4, en=1 for 40 cycles after reset -> sel_q 0 held 4 cycles, then 1..7 each 4 cycles, wrap single pulse on cycle sel_q returns to 0 (cycle 32 after release), y matches I[sel_q] each cycle.
- Scan with en toggled 0 for 3 cycles mid-dwell on channel 2 -> sel_q, y, cnt frozen; channel 2 then held for its remaining dwell cycles only (4 total enabled cycles).
- N=6, mode=0, s=6 then s=7 -> y=0, valid=0, sel_q keeps previous value; then s=5 -> y=I[5], valid=1.
- Scan, N=6, DWELL=1 -> sel_q 0,1,2,3,4,5,0 on consecutive cycles, wrap high only on the 5->0 edge; change I[3] while sel_q=3 with DWELL=3 -> y reflects new value next cycle.
- rst asserted for 1 cycle while scanning at sel_q=5, cnt=2 -> next cycle y=0, sel_q=0, valid=0, wrap=0; after release channel 0 held full DWELL.
